// File: rtl/bpm_uart_tx.sv
// Reports BPM values over a UART 8N1 line as "ddd\r\n" frames.
// Digits come from repeated subtraction; a one-deep pending slot keeps the newest value seen while busy.
module bpm_uart_tx #(
  parameter int CLK_PER_NS = 40,
  parameter int BAUD_RATE  = 115200,
  parameter int BPM_MAX    = 250
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [$clog2(BPM_MAX+1)-1:0]   bpm_i,
  input  logic                           bpm_valid,
  output logic                           tx_o,
  output logic                           busy_o
);

  localparam int BW          = $clog2(BPM_MAX + 1);
  localparam int RW          = (BW < 7) ? 7 : BW;
  localparam int CLK_PER_BIT = (1000000000 + CLK_PER_NS * BAUD_RATE / 2) / (CLK_PER_NS * BAUD_RATE);
  localparam int BCW         = $clog2(CLK_PER_BIT + 1);

  localparam logic [RW-1:0]  MAX_R    = RW'(BPM_MAX);
  localparam logic [RW-1:0]  HUNDRED  = RW'(100);
  localparam logic [RW-1:0]  TEN      = RW'(10);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(CLK_PER_BIT - 1);
  localparam logic [BCW-1:0] BAUD_ONE = BCW'(1);

  typedef enum logic [2:0] {IDLE, CONV, LOAD, START, DATA, STOP} state_t;

  state_t         state, state_nx;
  logic [RW-1:0]  rem, rem_nx;
  logic [3:0]     hund, hund_nx;
  logic [3:0]     tens, tens_nx;
  logic [RW-1:0]  pend_val, pend_val_nx;
  logic           pend_flag, pend_flag_nx;
  logic [2:0]     char_idx, char_idx_nx;
  logic [7:0]     shreg, shreg_nx;
  logic [BCW-1:0] baud_cnt, baud_cnt_nx;
  logic [2:0]     bit_cnt, bit_cnt_nx;
  logic           baud_done;
  logic           last_char;

  function automatic logic [RW-1:0] sat(input logic [BW-1:0] v);
    logic [RW-1:0] w;
    w = RW'(v);
    return (w > MAX_R) ? MAX_R : w;
  endfunction

  assign baud_done = (baud_cnt == '0);
  assign last_char = (char_idx == 3'd5);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      rem       <= '0;
      hund      <= '0;
      tens      <= '0;
      pend_val  <= '0;
      pend_flag <= 1'b0;
      char_idx  <= '0;
      shreg     <= '0;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
    end else begin
      state     <= state_nx;
      rem       <= rem_nx;
      hund      <= hund_nx;
      tens      <= tens_nx;
      pend_val  <= pend_val_nx;
      pend_flag <= pend_flag_nx;
      char_idx  <= char_idx_nx;
      shreg     <= shreg_nx;
      baud_cnt  <= baud_cnt_nx;
      bit_cnt   <= bit_cnt_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    rem_nx       = rem;
    hund_nx      = hund;
    tens_nx      = tens;
    pend_val_nx  = pend_val;
    pend_flag_nx = pend_flag;
    char_idx_nx  = char_idx;
    shreg_nx     = shreg;
    baud_cnt_nx  = baud_cnt;
    bit_cnt_nx   = bit_cnt;

    if (state != IDLE && bpm_valid) begin
      pend_val_nx  = sat(bpm_i);
      pend_flag_nx = 1'b1;
    end

    case (state)
      IDLE: begin
        if (bpm_valid) begin
          rem_nx      = sat(bpm_i);
          hund_nx     = '0;
          tens_nx     = '0;
          char_idx_nx = '0;
          state_nx    = CONV;
        end
      end
      CONV: begin
        if (rem >= HUNDRED) begin
          rem_nx  = rem - HUNDRED;
          hund_nx = hund + 4'd1;
        end else if (rem >= TEN) begin
          rem_nx  = rem - TEN;
          tens_nx = tens + 4'd1;
        end else begin
          state_nx = LOAD;
        end
      end
      LOAD: begin
        case (char_idx)
          3'd0:    shreg_nx = 8'h30 + {4'h0, hund};
          3'd1:    shreg_nx = 8'h30 + {4'h0, tens};
          3'd2:    shreg_nx = 8'h30 + {4'h0, rem[3:0]};
          3'd3:    shreg_nx = 8'h0D;
          default: shreg_nx = 8'h0A;
        endcase
        char_idx_nx = char_idx + 3'd1;
        baud_cnt_nx = BIT_LAST;
        state_nx    = START;
      end
      START: begin
        if (baud_done) begin
          baud_cnt_nx = BIT_LAST;
          bit_cnt_nx  = '0;
          state_nx    = DATA;
        end else begin
          baud_cnt_nx = baud_cnt - BAUD_ONE;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_cnt_nx = BIT_LAST;
          shreg_nx    = {1'b0, shreg[7:1]};
          if (bit_cnt == 3'd7) state_nx = STOP;
          else bit_cnt_nx = bit_cnt + 3'd1;
        end else begin
          baud_cnt_nx = baud_cnt - BAUD_ONE;
        end
      end
      STOP: begin
        // The LOAD cycle supplies the final idle-high cycle of a mid-frame stop bit.
        if (!last_char && baud_cnt == BAUD_ONE) begin
          state_nx = LOAD;
        end else if (last_char && baud_done) begin
          hund_nx     = '0;
          tens_nx     = '0;
          char_idx_nx = '0;
          if (bpm_valid) begin
            rem_nx       = sat(bpm_i);
            pend_flag_nx = 1'b0;
            state_nx     = CONV;
          end else if (pend_flag) begin
            rem_nx       = pend_val;
            pend_flag_nx = 1'b0;
            state_nx     = CONV;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          baud_cnt_nx = baud_cnt - BAUD_ONE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign tx_o   = (state == START) ? 1'b0 : (state == DATA) ? shreg[0] : 1'b1;
  assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_bpm_uart_tx.sv
// Directed bench for bpm_uart_tx: decodes every cycle of each frame against hand-written ASCII.
module tb_bpm_uart_tx;
  localparam int CPB = 217;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] bpm = 8'd0;
  logic       bpm_valid = 1'b0;
  logic       tx;
  logic       busy;

  int checks = 0;
  int errors = 0;

  always #20 clk = ~clk;

  bpm_uart_tx dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .bpm_i    (bpm),
    .bpm_valid(bpm_valid),
    .tx_o     (tx),
    .busy_o   (busy)
  );

  task automatic strobe(input logic [7:0] v);
    bpm       = v;
    bpm_valid = 1'b1;
    @(negedge clk);
    bpm_valid = 1'b0;
  endtask

  task automatic wait_start(output int lat, output int busy_low);
    lat      = 1;
    busy_low = 0;
    while (tx !== 1'b0 && lat < 40) begin
      if (busy !== 1'b1) busy_low++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_start(input string name, input int lat, input int busy_low);
    checks++;
    if (tx !== 1'b0 || lat > 16 || busy_low != 0) begin
      errors++;
      $display("FAIL %s start: tx=%b latency=%0d busy_low_cycles=%0d, required tx=0 latency<=16 busy_low_cycles=0",
               name, tx, lat, busy_low);
    end
  endtask

  task automatic check_frame(input logic [39:0] f, input int n_mid, input logic [7:0] mid0,
                             input logic [7:0] mid1, input bit last_strobe, input logic [7:0] last_val);
    logic [7:0] c;
    logic       exp;
    int         bad, first_bad;
    logic       first_tx, first_busy, first_exp;
    for (int ch = 0; ch < 5; ch++) begin
      c = f[39-8*ch -: 8];
      bad = 0; first_bad = -1; first_tx = 1'b0; first_busy = 1'b0; first_exp = 1'b0;
      for (int b = 0; b < 10; b++) begin
        exp = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : c[b-1];
        for (int k = 0; k < CPB; k++) begin
          bpm_valid = 1'b0;
          if (tx !== exp || busy !== 1'b1) begin
            if (bad == 0) begin
              first_bad = b * CPB + k; first_tx = tx; first_busy = busy; first_exp = exp;
            end
            bad++;
          end
          if (n_mid > 0 && ch == 1 && b == 0 && k == 3) begin bpm = mid0; bpm_valid = 1'b1; end
          if (n_mid > 1 && ch == 2 && b == 0 && k == 3) begin bpm = mid1; bpm_valid = 1'b1; end
          if (last_strobe && ch == 4 && b == 9 && k == CPB - 1) begin bpm = last_val; bpm_valid = 1'b1; end
          @(negedge clk);
        end
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL frame char %0d (0x%02h): %0d bad cycles, first at %0d: tx=%b busy=%b, required tx=%b busy=1",
                 ch, c, bad, first_bad, first_tx, first_busy, first_exp);
      end
    end
    bpm_valid = 1'b0;
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      errors++;
      $display("FAIL %s idle: busy=%b tx=%b, required busy=0 tx=1", name, busy, tx);
    end
  endtask

  task automatic test_reset;
    int bad;
    rst = 1'b1; bpm = 8'd120; bpm_valid = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("reset held");
    rst = 1'b0; bpm_valid = 1'b0;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy !== 1'b0 || tx !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL strobe during reset: %0d cycles busy or tx low, required 0", bad);
    end
  endtask

  task automatic test_basic;
    int lat, bl;
    strobe(8'd120);
    wait_start(lat, bl);
    check_start("120", lat, bl);
    check_frame({"120", 8'h0D, 8'h0A}, 0, 8'd0, 8'd0, 1'b0, 8'd0);
    check_idle("after 120");
  endtask

  task automatic test_zero_then_250;
    int lat, bl;
    strobe(8'd0);
    wait_start(lat, bl);
    check_start("000", lat, bl);
    check_frame({"000", 8'h0D, 8'h0A}, 1, 8'd250, 8'd0, 1'b0, 8'd0);
    wait_start(lat, bl);
    check_start("250 pending", lat, bl);
    check_frame({"250", 8'h0D, 8'h0A}, 0, 8'd0, 8'd0, 1'b0, 8'd0);
    check_idle("after 250");
  endtask

  task automatic test_saturation;
    int lat, bl;
    strobe(8'd255);
    wait_start(lat, bl);
    check_start("255 saturated", lat, bl);
    check_frame({"250", 8'h0D, 8'h0A}, 0, 8'd0, 8'd0, 1'b0, 8'd0);
    check_idle("after saturation");
  endtask

  task automatic test_newest_wins;
    int lat, bl;
    strobe(8'd60);
    wait_start(lat, bl);
    check_start("060", lat, bl);
    check_frame({"060", 8'h0D, 8'h0A}, 2, 8'd90, 8'd100, 1'b0, 8'd0);
  endtask

  task automatic test_stop_boundary;
    int lat, bl;
    wait_start(lat, bl);
    check_start("100 newest", lat, bl);
    check_frame({"100", 8'h0D, 8'h0A}, 0, 8'd0, 8'd0, 1'b1, 8'd75);
    wait_start(lat, bl);
    check_start("075 at last stop", lat, bl);
    check_frame({"075", 8'h0D, 8'h0A}, 0, 8'd0, 8'd0, 1'b0, 8'd0);
    check_idle("after 075");
  endtask

  task automatic test_reset_abort;
    int lat, bl, bad;
    strobe(8'd123);
    wait_start(lat, bl);
    check_start("123", lat, bl);
    repeat (23 * CPB) @(negedge clk);
    rst = 1'b1; bpm = 8'd200; bpm_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0; bpm_valid = 1'b0;
    check_idle("cycle after reset");
    bad = 0;
    repeat (2500) begin
      @(negedge clk);
      if (busy !== 1'b0 || tx !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL after abort: %0d cycles busy or tx low, required 0", bad);
    end
    strobe(8'd45);
    wait_start(lat, bl);
    check_start("045 after reset", lat, bl);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle("final reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_then_250();
    test_saturation();
    test_newest_wins();
    test_stop_boundary();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
